// File: rtl/rf_wb_if.sv
// rf_wb_if: write-back bus between the execute/load pipeline and the RF write-back arbiter.
//   master : pipeline side (drives load/ALU results, observes ready and the RF write port)
//   slave  : arbiter side (accepts results, drives we/dst_addr/dst/pend)
//   mem_vld/mem_addr/mem_data/mem_rdy : load result channel
//   alu_vld/alu_addr/alu_data/alu_rdy : ALU result channel
//   we/dst_addr/dst                   : registered RF write port
//   pend                              : per-register queued-write bitmap
interface rf_wb_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 4
);
   localparam int unsigned NREG = 2 ** AW;

   logic            mem_vld;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data;
   logic            mem_rdy;
   logic            alu_vld;
   logic [AW-1:0]   alu_addr;
   logic [DW-1:0]   alu_data;
   logic            alu_rdy;
   logic            we;
   logic [AW-1:0]   dst_addr;
   logic [DW-1:0]   dst;
   logic [NREG-1:0] pend;

   modport master (
      output mem_vld, mem_addr, mem_data, alu_vld, alu_addr, alu_data,
      input  mem_rdy, alu_rdy, we, dst_addr, dst, pend
   );

   modport slave (
      input  mem_vld, mem_addr, mem_data, alu_vld, alu_addr, alu_data,
      output mem_rdy, alu_rdy, we, dst_addr, dst, pend
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges load and ALU results onto the single RF write port.
//   Loads always win; ALU results that lose wait in an in-order skid FIFO.
//   Writes to R0 are accepted but suppressed.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rf_wb_if.slave (load/ALU inputs, mem_rdy/alu_rdy, we/dst_addr/dst, pend)
// Configuration:
//   RF_WB_PEND_EN : when defined, builds per-register occupancy counters driving pend;
//                   otherwise pend is tied to 0.
module rf_wb_arbiter #(
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned DEPTH = 4
) (
   input logic    clk,
   input logic    rst,
   rf_wb_if.slave bus
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(DEPTH) + 1;
   localparam int unsigned NREG = 2 ** AW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_t;

   wb_t           fifo [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          full;
   logic          empty;
   logic          alu_acc;
   logic          push;
   logic          pop;
   logic          sel_vld;
   wb_t           sel;
   wb_t           head;
   wb_t           alu_in;
   logic [CW-1:0] count_nxt;

   logic          we_q;
   logic [AW-1:0] dst_addr_q;
   logic [DW-1:0] dst_q;

   // Ready flags; forced low while reset is asserted
   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign bus.mem_rdy = ~rst;
   assign bus.alu_rdy = ~rst & ~full;

   assign head   = fifo[rd_ptr];
   assign alu_in = '{addr: bus.alu_addr, data: bus.alu_data};

   // Source select: load, then FIFO head, then direct ALU (only when FIFO empty)
   always_comb begin
      alu_acc   = bus.alu_vld & ~full;
      push      = 1'b0;
      pop       = 1'b0;
      sel_vld   = 1'b0;
      sel       = '0;
      if (bus.mem_vld) begin
         sel_vld = 1'b1;
         sel     = '{addr: bus.mem_addr, data: bus.mem_data};
         push    = alu_acc;
      end else if (!empty) begin
         sel_vld = 1'b1;
         sel     = head;
         pop     = 1'b1;
         push    = alu_acc;
      end else if (alu_acc) begin
         sel_vld = 1'b1;
         sel     = alu_in;
      end
      count_nxt = CW'(count + CW'(push) - CW'(pop));
   end

   // FIFO control and registered RF write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         we_q       <= 1'b0;
         dst_addr_q <= '0;
         dst_q      <= '0;
      end else begin
         if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
         if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));
         count <= count_nxt;
         // R0 targets consume their slot but never reach the RF
         we_q <= sel_vld && (sel.addr != '0);
         if (sel_vld && (sel.addr != '0)) begin
            dst_addr_q <= sel.addr;
            dst_q      <= sel.data;
         end
      end
   end

   // FIFO storage; contents are don't-care while count says empty
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= alu_in;
   end

   assign bus.we       = we_q;
   assign bus.dst_addr = dst_addr_q;
   assign bus.dst      = dst_q;

`ifdef RF_WB_PEND_EN
   logic [CW-1:0]   occ     [NREG];
   logic [CW-1:0]   occ_nxt [NREG];
   logic [NREG-1:0] pend_q;

   // Occupancy per destination; push and pop to the same register cancel out
   always_comb begin
      for (int i = 0; i < int'(NREG); i++) occ_nxt[i] = occ[i];
      if (push && (bus.alu_addr != '0))
         occ_nxt[bus.alu_addr] = CW'(occ_nxt[bus.alu_addr] + CW'(1));
      if (pop && (head.addr != '0))
         occ_nxt[head.addr] = CW'(occ_nxt[head.addr] - CW'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) occ[i] <= '0;
         pend_q <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) begin
            occ[i]    <= occ_nxt[i];
            pend_q[i] <= (occ_nxt[i] != '0);
         end
      end
   end

   assign bus.pend = pend_q;
`else
   assign bus.pend = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed + randomized check of rf_wb_arbiter against a queue-based
// reference model of the write-back priority rules.
module tb_rf_wb_arbiter;
   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   rf_wb_if #(.DW(DW), .AW(AW)) bus ();

   rf_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   ent_t          q[$];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_dst;
   logic          hold_known;
   logic          obs_rdy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_pend();
      logic [15:0] p;
      p = '0;
`ifdef RF_WB_PEND_EN
      foreach (q[i]) if (q[i].addr != '0) p[q[i].addr] = 1'b1;
`endif
      return p;
   endfunction

   // One clock of stimulus; entered and left just after a falling edge
   task automatic step(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       output logic acc);
      logic          exp_rdy;
      logic          wr;
      logic          exp_we;
      ent_t          e;
      bus.mem_vld  = mv;
      bus.mem_addr = ma;
      bus.mem_data = md;
      bus.alu_vld  = av;
      bus.alu_addr = aa;
      bus.alu_data = ad;
      #1;
      exp_rdy = (q.size() < DEPTH);
      obs_rdy = bus.alu_rdy;
      check("alu_rdy", 32'(bus.alu_rdy), 32'(exp_rdy));
      check("mem_rdy", 32'(bus.mem_rdy), 32'd1);
      acc = av && exp_rdy;
      wr  = 1'b0;
      e   = '{addr: aa, data: ad};
      if (mv) begin
         wr = 1'b1; e = '{addr: ma, data: md};
         if (acc) q.push_back('{addr: aa, data: ad});
      end else if (q.size() > 0) begin
         wr = 1'b1; e = q.pop_front();
         if (acc) q.push_back('{addr: aa, data: ad});
      end else if (acc) begin
         wr = 1'b1;
      end
      exp_we = wr && (e.addr != '0);
      @(negedge clk);
      check("we", 32'(bus.we), 32'(exp_we));
      if (exp_we) begin
         exp_addr   = e.addr;
         exp_dst    = e.data;
         hold_known = 1'b1;
         check("dst_addr", 32'(bus.dst_addr), 32'(exp_addr));
         check("dst", 32'(bus.dst), 32'(exp_dst));
      end else if (wr) begin
         hold_known = 1'b0;
      end else if (hold_known) begin
         check("dst_addr_hold", 32'(bus.dst_addr), 32'(exp_addr));
         check("dst_hold", 32'(bus.dst), 32'(exp_dst));
      end
      check("pend", 32'(bus.pend), 32'(model_pend()));
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic reset_now();
      rst = 1'b1;
      #1;
      check("rst_we", 32'(bus.we), 32'd0);
      check("rst_dst", 32'(bus.dst), 32'd0);
      check("rst_dst_addr", 32'(bus.dst_addr), 32'd0);
      check("rst_alu_rdy", 32'(bus.alu_rdy), 32'd0);
      check("rst_mem_rdy", 32'(bus.mem_rdy), 32'd0);
      check("rst_pend", 32'(bus.pend), 32'd0);
      q.delete();
      exp_addr   = '0;
      exp_dst    = '0;
      hold_known = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_alu_rdy", 32'(bus.alu_rdy), 32'd1);
      @(negedge clk);
   endtask

   initial begin : main
      logic          acc;
      int            idx;
      int            accepts;
      int            nwr;
      logic [AW-1:0] order [8];
      logic          av_r;
      logic [AW-1:0] aa_r;
      logic [DW-1:0] ad_r;

      bus.mem_vld = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
      bus.alu_vld = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
      exp_addr = '0; exp_dst = '0; hold_known = 1'b1; obs_rdy = 1'b0;
      #2;
      reset_now();

      // 1: lone ALU result goes straight through
      step(0, 0, 0, 1, 4'd3, 16'h1234, acc);
      check("t1_we", 32'(bus.we), 32'd1);
      check("t1_addr", 32'(bus.dst_addr), 32'd3);
      check("t1_dst", 32'(bus.dst), 32'h1234);
      step(0, 0, 0, 0, 0, 0, acc);
      check("t1_idle_we", 32'(bus.we), 32'd0);

      // 2: simultaneous load and ALU; load first, ALU next cycle
      step(1, 4'd5, 16'hAAAA, 1, 4'd6, 16'h5555, acc);
      check("t2_rdy", 32'(obs_rdy), 32'd1);
      check("t2_first", 32'(bus.dst_addr), 32'd5);
      step(0, 0, 0, 0, 0, 0, acc);
      check("t2_second", 32'(bus.dst_addr), 32'd6);
      check("t2_second_dst", 32'(bus.dst), 32'h5555);

      // 3: loads hold 6 cycles while ALU offers R1..R6 with retry on stall
      idx = 1; accepts = 0;
      for (int c = 0; c < 6; c++) begin
         step(1, AW'(8 + c), DW'(16'hC000 + c), 1, AW'(idx), DW'(16'h0100 * idx), acc);
         if (obs_rdy) begin accepts++; idx++; end
      end
      check("t3_accepts", 32'(accepts), 32'd4);
      nwr = 0;
      for (int c = 0; c < 12; c++) begin
         step(0, 0, 0, idx <= 6, AW'(idx), DW'(16'h0100 * idx), acc);
         if (acc) idx++;
         if (bus.we && nwr < 8) begin order[nwr] = bus.dst_addr; nwr++; end
      end
      check("t3_nwrites", 32'(nwr), 32'd6);
      for (int i = 0; i < 6; i++) check("t3_order", 32'(order[i]), 32'(i + 1));

      // 4: R0 write suppressed but consumes its slot
      step(0, 0, 0, 1, 4'd0, 16'hFFFF, acc);
      check("t4_r0_we", 32'(bus.we), 32'd0);
      step(0, 0, 0, 1, 4'd2, 16'h2222, acc);
      check("t4_r2_we", 32'(bus.we), 32'd1);
      check("t4_r2_addr", 32'(bus.dst_addr), 32'd2);

      // 6: two queued R7 writes keep pend[7] until the second pops
      step(1, 4'd9, 16'h0009, 1, 4'd7, 16'h7001, acc);
      step(1, 4'd9, 16'h0009, 1, 4'd7, 16'h7002, acc);
`ifdef RF_WB_PEND_EN
      check("t6_pend_set", 32'(bus.pend[7]), 32'd1);
`endif
      step(0, 0, 0, 0, 0, 0, acc);
`ifdef RF_WB_PEND_EN
      check("t6_pend_mid", 32'(bus.pend[7]), 32'd1);
`endif
      step(0, 0, 0, 0, 0, 0, acc);
      check("t6_pend_clear", 32'(bus.pend), 32'd0);
      check("t6_last", 32'(bus.dst), 32'h7002);

      // 5: reset mid-drain with three entries queued
      for (int c = 0; c < 4; c++) step(1, 4'd10, DW'(c), 1, AW'(11 + c), DW'(16'hB000 + c), acc);
      step(0, 0, 0, 0, 0, 0, acc);
      check("t5_queued", 32'(q.size()), 32'd3);
      #2;
      reset_now();
      for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 0, acc);

      // Randomized traffic with stalled ALU results held until accepted
      av_r = 1'b0; aa_r = '0; ad_r = '0;
      for (int c = 0; c < 500; c++) begin
         if (!av_r) begin
            av_r = ($urandom_range(0, 9) < 7);
            aa_r = AW'($urandom_range(0, 15));
            ad_r = DW'($urandom);
         end
         if (c == 250) begin
            #2;
            reset_now();
            av_r = 1'b0;
         end
         step($urandom_range(0, 9) < 4, AW'($urandom_range(0, 15)), DW'($urandom),
              av_r, aa_r, ad_r, acc);
         if (acc) av_r = 1'b0;
      end
      for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 0, acc);
      check("final_empty_pend", 32'(bus.pend), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
